conv1d_mac_pipeline: RTL and testbench

- Compute stage directly downstream of the L0 weight/input buffers and upstream of the output SRAM write port.
- Consumes one (weight, input) operand pair per accepted cycle. Each output is a signed multiply-accumulate over Weight_Nums consecutive pairs, computed in a 4-stage pipeline.
- Emits Output_Nums results with sequential write addresses, then pulses Done.

---
 rtl/conv1d_mac_pipeline.sv | 144 ++++++++++++++
 tb/tb_conv1d_mac_pipeline.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_mac_pipeline.sv
// conv1d_mac_pipeline: 4-stage signed MAC over Weight_Nums taps per output, emitting Output_Nums addressed results
module conv1d_mac_pipeline #(
    parameter int Data_Width_In     = 8,
    parameter int Data_Width_Out    = 2 * Data_Width_In,
    parameter int Weight_Nums       = 3,
    parameter int Output_Nums       = 16,
    parameter int Output_Addr_Width = 4,
    parameter int Tap_Cnt_Width     = 2
) (
    input  logic                         clk,
    input  logic                         Reset,
    input  logic                         Start,
    input  logic                         Abort,
    input  logic                         In_Valid,
    output logic                         In_Ready,
    input  logic [Data_Width_In-1:0]     Weight_Data_Read,
    input  logic [Data_Width_In-1:0]     Input_Data_Read,
    output logic [Data_Width_Out-1:0]    Output_Data_Write,
    output logic [Output_Addr_Width-1:0] Output_Addr_Write,
    output logic                         Out_Valid,
    input  logic                         Out_Ready,
    output logic                         Busy,
    output logic                         Done
);
    localparam int Pairs          = Weight_Nums * Output_Nums;
    localparam int Pair_Cnt_Width = $clog2(Pairs + 1);
    localparam int Ext            = Data_Width_Out - Data_Width_In;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state_q, state_d;
    logic [Tap_Cnt_Width-1:0]     tap_q, tap_d;
    logic [Pair_Cnt_Width-1:0]    pair_q, pair_d;
    logic [Output_Addr_Width-1:0] addr_q, addr_d;

    logic                      s1_v_q, s1_first_q, s1_last_q;
    logic [Data_Width_In-1:0]  s1_w_q, s1_x_q;
    logic                      s2_v_q, s2_first_q, s2_last_q;
    logic [Data_Width_Out-1:0] s2_prod_q;
    logic                      s3_v_q, s3_last_q;
    logic [Data_Width_Out-1:0] acc_q;
    logic                      out_v_q;
    logic [Data_Width_Out-1:0] out_data_q;

    logic en, accept, handshake, start_run, tap_last, last_pair, last_out;
    logic [Data_Width_Out-1:0] w_ext, x_ext, prod;

    assign en        = !out_v_q | Out_Ready;
    assign handshake = out_v_q & Out_Ready;
    assign accept    = (state_q == RUN) & In_Valid & en;
    assign start_run = (state_q == IDLE) & Start;
    assign tap_last  = tap_q == Tap_Cnt_Width'(Weight_Nums - 1);
    assign last_pair = pair_q == Pair_Cnt_Width'(Pairs - 1);
    assign last_out  = handshake & (addr_q == Output_Addr_Width'(Output_Nums - 1));

    // Sign-extending both operands first makes the low Data_Width_Out bits of an unsigned multiply the signed product
    assign w_ext = {{Ext{s1_w_q[Data_Width_In-1]}}, s1_w_q};
    assign x_ext = {{Ext{s1_x_q[Data_Width_In-1]}}, s1_x_q};
    assign prod  = w_ext * x_ext;

    assign In_Ready          = (state_q == RUN) & en;
    assign Out_Valid         = out_v_q;
    assign Output_Data_Write = out_data_q;
    assign Output_Addr_Write = addr_q;
    assign Busy              = (state_q == RUN) | (state_q == DRAIN);
    assign Done              = state_q == DONE;

    // Run sequencing: Abort overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = RUN;
            RUN:     if (accept && last_pair) state_d = DRAIN;
            DRAIN:   if (last_out) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (Abort) state_d = IDLE;
    end

    // Tap/pair counters advance per accepted pair; address advances per result handshake
    always_comb begin
        tap_d  = (Abort | start_run) ? '0 : accept ? (tap_last ? '0 : tap_q + Tap_Cnt_Width'(1)) : tap_q;
        pair_d = (Abort | start_run) ? '0 : accept ? pair_q + Pair_Cnt_Width'(1) : pair_q;
        addr_d = (Abort | start_run) ? '0 : handshake ? addr_q + Output_Addr_Width'(1) : addr_q;
    end

    // Control state and counters
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            tap_q   <= '0;
            pair_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            pair_q  <= pair_d;
            addr_q  <= addr_d;
        end
    end

    // Datapath: every stage holds while the output register is full and not being taken
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            s1_v_q     <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_w_q     <= '0;
            s1_x_q     <= '0;
            s2_v_q     <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_prod_q  <= '0;
            s3_v_q     <= 1'b0;
            s3_last_q  <= 1'b0;
            acc_q      <= '0;
            out_v_q    <= 1'b0;
            out_data_q <= '0;
        end else if (Abort) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            s3_v_q    <= 1'b0;
            s3_last_q <= 1'b0;
            acc_q     <= '0;
            out_v_q   <= 1'b0;
        end else if (en) begin
            s1_v_q     <= accept;
            s1_first_q <= tap_q == '0;
            s1_last_q  <= tap_last;
            s1_w_q     <= Weight_Data_Read;
            s1_x_q     <= Input_Data_Read;
            s2_v_q     <= s1_v_q;
            s2_first_q <= s1_first_q;
            s2_last_q  <= s1_last_q;
            s2_prod_q  <= prod;
            s3_v_q     <= s2_v_q;
            s3_last_q  <= s2_v_q & s2_last_q;
            if (s2_v_q) acc_q <= s2_first_q ? s2_prod_q : acc_q + s2_prod_q;
            out_v_q    <= s3_v_q & s3_last_q;
            if (s3_v_q && s3_last_q) out_data_q <= acc_q;
        end
    end
endmodule

// File: tb/tb_conv1d_mac_pipeline.sv
// tb_conv1d_mac_pipeline: directed-vector checks of the conv1d MAC pipeline
module tb_conv1d_mac_pipeline;
    localparam int NP = 48;
    localparam int ON = 16;

    logic clk = 1'b0;
    logic Reset, Start, Abort, In_Valid, In_Ready, Out_Valid, Out_Ready, Busy, Done;
    logic [7:0]  Weight_Data_Read, Input_Data_Read;
    logic [15:0] Output_Data_Write;
    logic [3:0]  Output_Addr_Write;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc = 0;
    int done_cnt = 0;
    int first_valid_cyc = -1;
    int acc_cyc = 0;
    bit timeout = 1'b0;

    logic [7:0]  wv[NP];
    logic [7:0]  xv[NP];
    logic [15:0] exp_d[ON];
    logic [15:0] got_d[$];
    logic [3:0]  got_a[$];

    conv1d_mac_pipeline dut (
        .clk(clk), .Reset(Reset), .Start(Start), .Abort(Abort),
        .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Weight_Data_Read(Weight_Data_Read), .Input_Data_Read(Input_Data_Read),
        .Output_Data_Write(Output_Data_Write), .Output_Addr_Write(Output_Addr_Write),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe handshakes, Done pulses and the first Out_Valid away from the active edge
    always @(negedge clk) begin
        if (Reset && Out_Valid && Out_Ready) begin
            got_d.push_back(Output_Data_Write);
            got_a.push_back(Output_Addr_Write);
        end
        if (Done) done_cnt++;
        if (Out_Valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    end

    task automatic load_basic();
        for (int k = 0; k < ON; k++)
            for (int j = 0; j < 3; j++) begin
                wv[3*k+j] = (k == 0) ? 8'(j + 1) : 8'd1;
                xv[3*k+j] = (k == 0) ? 8'(j + 1) : 8'(k);
            end
        exp_d[0] = 16'd14;
        for (int k = 1; k < ON; k++) exp_d[k] = 16'(3 * k);
    endtask

    task automatic load_signed();
        load_basic();
        for (int j = 0; j < 3; j++) begin
            wv[j] = 8'h80;
            xv[j] = 8'h80;
        end
        wv[3] = 8'hFF; xv[3] = 8'd5;
        wv[4] = 8'd2;  xv[4] = 8'hFD;
        wv[5] = 8'd0;  xv[5] = 8'd7;
        exp_d[0] = 16'hC000;
        exp_d[1] = 16'hFFF5;
    endtask

    task automatic clear_obs();
        got_d.delete();
        got_a.delete();
        first_valid_cyc = -1;
        timeout = 1'b0;
    endtask

    task automatic start_run();
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
    endtask

    task automatic feed(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            In_Valid = 1'b1;
            Weight_Data_Read = wv[i];
            Input_Data_Read = xv[i];
            while (1) begin
                @(negedge clk);
                if (In_Ready) break;
                if (++t > 1000) begin
                    timeout = 1'b1;
                    In_Valid = 1'b0;
                    return;
                end
            end
            @(posedge clk); #1;
            if (i == 2) acc_cyc = cyc;
            In_Valid = 1'b0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_done(input int d0);
        int t = 0;
        while (done_cnt == d0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == d0) timeout = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        #2;
        chk_cnt++; if (Out_Valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", Out_Valid); else pass_cnt++;
        chk_cnt++; if (In_Ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", In_Ready); else pass_cnt++;
        chk_cnt++; if (Busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", Busy); else pass_cnt++;
        chk_cnt++; if (Done !== 1'b0) $display("FAIL reset_done got %b exp 0", Done); else pass_cnt++;
        chk_cnt++; if (Output_Data_Write !== 16'h0) $display("FAIL reset_data got %h exp 0000", Output_Data_Write); else pass_cnt++;
        chk_cnt++; if (Output_Addr_Write !== 4'h0) $display("FAIL reset_addr got %h exp 0", Output_Addr_Write); else pass_cnt++;
        @(negedge clk);
        Reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int d0 = done_cnt;
        load_basic();
        clear_obs();
        start_run();
        chk_cnt++; if (Busy !== 1'b1) $display("FAIL basic_busy_run got %b exp 1", Busy); else pass_cnt++;
        feed(NP, 0);
        wait_done(d0);
        chk_cnt++; if (timeout !== 1'b0) $display("FAIL basic_timeout got %b exp 0", timeout); else pass_cnt++;
        chk_cnt++; if (first_valid_cyc !== acc_cyc + 3) $display("FAIL basic_latency got %0d exp %0d", first_valid_cyc, acc_cyc + 3); else pass_cnt++;
        chk_cnt++; if (got_d.size() !== ON) $display("FAIL basic_count got %0d exp %0d", got_d.size(), ON); else pass_cnt++;
        for (int i = 0; i < ON && i < got_d.size(); i++) begin
            chk_cnt++;
            if (got_d[i] !== exp_d[i] || got_a[i] !== 4'(i))
                $display("FAIL basic_out%0d got %h@%0d exp %h@%0d", i, got_d[i], got_a[i], exp_d[i], i);
            else pass_cnt++;
        end
        chk_cnt++; if (done_cnt !== d0 + 1) $display("FAIL basic_done_pulses got %0d exp %0d", done_cnt - d0, 1); else pass_cnt++;
        chk_cnt++; if (Busy !== 1'b0) $display("FAIL basic_busy_end got %b exp 0", Busy); else pass_cnt++;
    endtask

    task automatic test_signed();
        int d0 = done_cnt;
        load_signed();
        clear_obs();
        start_run();
        feed(NP, 0);
        wait_done(d0);
        chk_cnt++; if (timeout !== 1'b0) $display("FAIL signed_timeout got %b exp 0", timeout); else pass_cnt++;
        chk_cnt++; if (got_d.size() !== ON) $display("FAIL signed_count got %0d exp %0d", got_d.size(), ON); else pass_cnt++;
        for (int i = 0; i < ON && i < got_d.size(); i++) begin
            chk_cnt++;
            if (got_d[i] !== exp_d[i] || got_a[i] !== 4'(i))
                $display("FAIL signed_out%0d got %h@%0d exp %h@%0d", i, got_d[i], got_a[i], exp_d[i], i);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int d0 = done_cnt;
        load_basic();
        clear_obs();
        start_run();
        fork
            feed(NP, 0);
            begin
                int t = 0;
                do begin
                    @(posedge clk); #1;
                    t++;
                end while (!(Out_Valid && Output_Addr_Write == 4'd2) && t < 500);
                if (t >= 500) timeout = 1'b1;
                Out_Ready = 1'b0;
                repeat (5) begin
                    @(posedge clk); #1;
                    chk_cnt++; if (Out_Valid !== 1'b1) $display("FAIL bp_valid got %b exp 1", Out_Valid); else pass_cnt++;
                    chk_cnt++; if (Output_Data_Write !== exp_d[2]) $display("FAIL bp_data got %h exp %h", Output_Data_Write, exp_d[2]); else pass_cnt++;
                    chk_cnt++; if (Output_Addr_Write !== 4'd2) $display("FAIL bp_addr got %0d exp 2", Output_Addr_Write); else pass_cnt++;
                    chk_cnt++; if (In_Ready !== 1'b0) $display("FAIL bp_in_ready got %b exp 0", In_Ready); else pass_cnt++;
                end
                Out_Ready = 1'b1;
            end
        join
        wait_done(d0);
        chk_cnt++; if (timeout !== 1'b0) $display("FAIL bp_timeout got %b exp 0", timeout); else pass_cnt++;
        chk_cnt++; if (got_d.size() !== ON) $display("FAIL bp_count got %0d exp %0d", got_d.size(), ON); else pass_cnt++;
        for (int i = 0; i < ON && i < got_d.size(); i++) begin
            chk_cnt++;
            if (got_d[i] !== exp_d[i] || got_a[i] !== 4'(i))
                $display("FAIL bp_out%0d got %h@%0d exp %h@%0d", i, got_d[i], got_a[i], exp_d[i], i);
            else pass_cnt++;
        end
    endtask

    task automatic test_gaps();
        int d0 = done_cnt;
        load_basic();
        clear_obs();
        start_run();
        feed(NP, 2);
        wait_done(d0);
        chk_cnt++; if (timeout !== 1'b0) $display("FAIL gaps_timeout got %b exp 0", timeout); else pass_cnt++;
        chk_cnt++; if (got_d.size() !== ON) $display("FAIL gaps_count got %0d exp %0d", got_d.size(), ON); else pass_cnt++;
        for (int i = 0; i < ON && i < got_d.size(); i++) begin
            chk_cnt++;
            if (got_d[i] !== exp_d[i] || got_a[i] !== 4'(i))
                $display("FAIL gaps_out%0d got %h@%0d exp %h@%0d", i, got_d[i], got_a[i], exp_d[i], i);
            else pass_cnt++;
        end
    endtask

    task automatic test_abort();
        int d0 = done_cnt;
        load_basic();
        clear_obs();
        start_run();
        feed(20, 0);
        Abort = 1'b1;
        @(posedge clk); #1;
        Abort = 1'b0;
        chk_cnt++; if (Out_Valid !== 1'b0) $display("FAIL abort_out_valid got %b exp 0", Out_Valid); else pass_cnt++;
        chk_cnt++; if (Busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", Busy); else pass_cnt++;
        chk_cnt++; if (In_Ready !== 1'b0) $display("FAIL abort_in_ready got %b exp 0", In_Ready); else pass_cnt++;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk_cnt++; if (done_cnt !== d0) $display("FAIL abort_no_done got %0d exp %0d", done_cnt, d0); else pass_cnt++;
        chk_cnt++; if (Out_Valid !== 1'b0) $display("FAIL abort_quiet got %b exp 0", Out_Valid); else pass_cnt++;
        clear_obs();
        start_run();
        feed(NP, 0);
        wait_done(d0);
        chk_cnt++; if (timeout !== 1'b0) $display("FAIL abort_rerun_timeout got %b exp 0", timeout); else pass_cnt++;
        chk_cnt++; if (got_d.size() !== ON) $display("FAIL abort_rerun_count got %0d exp %0d", got_d.size(), ON); else pass_cnt++;
        for (int i = 0; i < ON && i < got_d.size(); i++) begin
            chk_cnt++;
            if (got_d[i] !== exp_d[i] || got_a[i] !== 4'(i))
                $display("FAIL abort_rerun_out%0d got %h@%0d exp %h@%0d", i, got_d[i], got_a[i], exp_d[i], i);
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        int d0 = done_cnt;
        load_basic();
        clear_obs();
        start_run();
        feed(NP, 0);
        chk_cnt++; if (Busy !== 1'b1) $display("FAIL ar_busy_drain got %b exp 1", Busy); else pass_cnt++;
        #2;
        Reset = 1'b0;
        #1;
        chk_cnt++; if (Out_Valid !== 1'b0) $display("FAIL ar_out_valid got %b exp 0", Out_Valid); else pass_cnt++;
        chk_cnt++; if (Output_Data_Write !== 16'h0) $display("FAIL ar_data got %h exp 0000", Output_Data_Write); else pass_cnt++;
        chk_cnt++; if (Output_Addr_Write !== 4'h0) $display("FAIL ar_addr got %h exp 0", Output_Addr_Write); else pass_cnt++;
        chk_cnt++; if (Busy !== 1'b0) $display("FAIL ar_busy got %b exp 0", Busy); else pass_cnt++;
        chk_cnt++; if (In_Ready !== 1'b0) $display("FAIL ar_in_ready got %b exp 0", In_Ready); else pass_cnt++;
        Start = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk_cnt++; if (Busy !== 1'b0) $display("FAIL ar_start_ignored got %b exp 0", Busy); else pass_cnt++;
        Start = 1'b0;
        @(negedge clk);
        Reset = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk_cnt++; if (Busy !== 1'b0) $display("FAIL ar_idle_after got %b exp 0", Busy); else pass_cnt++;
        chk_cnt++; if (done_cnt !== d0) $display("FAIL ar_no_done got %0d exp %0d", done_cnt, d0); else pass_cnt++;
    endtask

    initial begin
        Reset = 1'b0;
        Start = 1'b0;
        Abort = 1'b0;
        In_Valid = 1'b0;
        Out_Ready = 1'b1;
        Weight_Data_Read = '0;
        Input_Data_Read = '0;
        test_reset();
        test_basic();
        test_signed();
        test_backpressure();
        test_gaps();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
